// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operand/result handshake bundle for alu_seq
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             i_Valid;
  logic             o_Ready;
  logic [WIDTH-1:0] i_X;
  logic [WIDTH-1:0] i_Y;
  logic             i_ZX;
  logic             i_NX;
  logic             i_ZY;
  logic             i_NY;
  logic             i_F;
  logic             i_NO;
  logic [1:0]       i_Mode;
  logic             o_Valid;
  logic             i_Ready;
  logic [WIDTH-1:0] o_ALU;
  logic             o_ZR;
  logic             o_NG;
  logic             o_CY;
  logic             o_OV;

  modport slave (
    input  i_Valid, i_X, i_Y, i_ZX, i_NX, i_ZY, i_NY, i_F, i_NO, i_Mode, i_Ready,
    output o_Ready, o_Valid, o_ALU, o_ZR, o_NG, o_CY, o_OV
  );

  modport master (
    output i_Valid, i_X, i_Y, i_ZX, i_NX, i_ZY, i_NY, i_F, i_NO, i_Mode, i_Ready,
    input  o_Ready, o_Valid, o_ALU, o_ZR, o_NG, o_CY, o_OV
  );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential Hack ALU with shifts and iterative multiply
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic    i_Clk,
  input  logic    i_Rst,
  alu_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] alu_q, alu_d;
  logic             zr_q, zr_d;
  logic             ng_q, ng_d;
  logic             cy_q, cy_d;
  logic             ov_q, ov_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             no_q, no_d;

  logic [WIDTH-1:0] xp;
  logic [WIDTH-1:0] yp;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] core;
  logic [WIDTH-1:0] fin;
  logic             cy_core;
  logic             ov_core;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] mul_fin;
  logic             ready;
  logic             accept;

  assign ready   = (state_q == IDLE) || ((state_q == DONE) && bus.i_Ready);
  assign accept  = bus.i_Valid && ready;

  assign bus.o_Ready = ready;
  assign bus.o_Valid = (state_q == DONE);
  assign bus.o_ALU   = alu_q;
  assign bus.o_ZR    = zr_q;
  assign bus.o_NG    = ng_q;
  assign bus.o_CY    = cy_q;
  assign bus.o_OV    = ov_q;

  // Zero/negate the raw operands into x' and y'
  always_comb begin
    xp = bus.i_ZX ? '0 : bus.i_X;
    if (bus.i_NX) xp = ~xp;
    yp = bus.i_ZY ? '0 : bus.i_Y;
    if (bus.i_NY) yp = ~yp;
  end

  // Single-cycle result for add/and and the two shifts, plus adder flags
  always_comb begin
    amt     = yp[SHW-1:0];
    sum     = {1'b0, xp} + {1'b0, yp};
    core    = '0;
    cy_core = 1'b0;
    ov_core = 1'b0;
    case (bus.i_Mode)
      2'd0: begin
        if (bus.i_F) begin
          core    = sum[WIDTH-1:0];
          cy_core = sum[WIDTH];
          ov_core = (xp[WIDTH-1] == yp[WIDTH-1]) && (sum[WIDTH-1] != xp[WIDTH-1]);
        end else begin
          core = xp & yp;
        end
      end
      2'd1:    core = xp << amt;
      2'd2:    core = $unsigned($signed(xp) >>> amt);
      default: core = '0;
    endcase
    fin = bus.i_NO ? ~core : core;
  end

  // One shift-add step of the multiplier and its output-negated form
  always_comb begin
    acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mul_fin  = no_q ? ~acc_step : acc_step;
  end

  // Next-state and registered-result logic
  always_comb begin
    state_d  = state_q;
    alu_d    = alu_q;
    zr_d     = zr_q;
    ng_d     = ng_q;
    cy_d     = cy_q;
    ov_d     = ov_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    no_d     = no_q;
    case (state_q)
      IDLE, DONE: begin
        if ((state_q == DONE) && bus.i_Ready) state_d = IDLE;
        if (accept) begin
          if (bus.i_Mode == 2'd3) begin
            state_d  = BUSY;
            mcand_d  = xp;
            mplier_d = yp;
            no_d     = bus.i_NO;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            state_d = DONE;
            alu_d   = fin;
            zr_d    = (fin == '0);
            ng_d    = fin[WIDTH-1];
            cy_d    = cy_core;
            ov_d    = ov_core;
          end
        end
      end
      BUSY: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d = DONE;
          alu_d   = mul_fin;
          zr_d    = (mul_fin == '0);
          ng_d    = mul_fin[WIDTH-1];
          cy_d    = 1'b0;
          ov_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers, cleared asynchronously
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q  <= IDLE;
      alu_q    <= '0;
      zr_q     <= 1'b0;
      ng_q     <= 1'b0;
      cy_q     <= 1'b0;
      ov_q     <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      no_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      alu_q    <= alu_d;
      zr_q     <= zr_d;
      ng_q     <= ng_d;
      cy_q     <= cy_d;
      ov_q     <= ov_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      no_q     <= no_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq
module tb_alu_seq;
  localparam int     W = 16;
  localparam longint P = longint'(1) << W;

  typedef struct packed {
    logic [W-1:0] alu;
    logic         zr;
    logic         ng;
    logic         cy;
    logic         ov;
  } res_t;

  typedef struct {
    res_t r;
    int   due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q[$];
  exp_t e_new;
  res_t m_r;
  logic m_ev;
  logic m_er;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .bus  (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands after zx/nx/zy/ny
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic [5:0] b, input logic [1:0] m);
    logic [W-1:0] xp, yp, fin;
    longint ux, uy, sx, sy, r, s, p2, qq;
    int amt;
    res_t o;
    xp = b[5] ? '0 : x;
    if (b[4]) xp = ~xp;
    yp = b[3] ? '0 : y;
    if (b[2]) yp = ~yp;
    ux = longint'(xp);
    uy = longint'(yp);
    sx = (ux >= P / 2) ? ux - P : ux;
    sy = (uy >= P / 2) ? uy - P : uy;
    amt = int'(uy % W);
    p2 = longint'(1) << amt;
    o.cy = 1'b0;
    o.ov = 1'b0;
    r = 0;
    case (m)
      2'd0: begin
        if (b[1]) begin
          s = ux + uy;
          r = s % P;
          o.cy = (s >= P);
          s = sx + sy;
          o.ov = (s >= P / 2) || (s < -(P / 2));
        end else begin
          r = longint'(xp & yp);
        end
      end
      2'd1: r = (ux * p2) % P;
      2'd2: begin
        qq = sx / p2;
        if (sx < 0 && qq * p2 != sx) qq = qq - 1;
        r = (qq + P) % P;
      end
      default: r = (ux * uy) % P;
    endcase
    fin = r[W-1:0];
    if (b[0]) fin = ~fin;
    o.alu = fin;
    o.zr = (fin == '0);
    o.ng = fin[W-1];
    return o;
  endfunction

  // Cycle-by-cycle comparison of the DUT against the queued model results
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      m_ev = (q.size() > 0) && (cyc >= q[0].due);
      if (q.size() == 0)  m_er = 1'b1;
      else if (!m_ev)     m_er = 1'b0;
      else                m_er = bus.i_Ready;
      chk("cmp o_Valid", bus.o_Valid, m_ev);
      chk("cmp o_Ready", bus.o_Ready, m_er);
      if (m_ev) begin
        m_r = q[0].r;
        chk("cmp o_ALU", bus.o_ALU, m_r.alu);
        chk("cmp o_ZR", bus.o_ZR, m_r.zr);
        chk("cmp o_NG", bus.o_NG, m_r.ng);
        chk("cmp o_CY", bus.o_CY, m_r.cy);
        chk("cmp o_OV", bus.o_OV, m_r.ov);
        if (bus.i_Ready) void'(q.pop_front());
      end
      if (bus.i_Valid && m_er) begin
        e_new.r = model(bus.i_X, bus.i_Y,
                        {bus.i_ZX, bus.i_NX, bus.i_ZY, bus.i_NY, bus.i_F, bus.i_NO},
                        bus.i_Mode);
        e_new.due = cyc + ((bus.i_Mode == 2'd3) ? W + 1 : 1);
        q.push_back(e_new);
      end
    end
    cyc++;
  end

  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [5:0] b, input logic [1:0] m);
    bus.i_X = x;
    bus.i_Y = y;
    {bus.i_ZX, bus.i_NX, bus.i_ZY, bus.i_NY, bus.i_F, bus.i_NO} = b;
    bus.i_Mode = m;
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [5:0] b, input logic [1:0] m,
                        output res_t got, output int lat, output int rlow);
    @(posedge clk); #1;
    drive(x, y, b, m);
    bus.i_Valid = 1'b1;
    lat = 0;
    rlow = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.o_Ready) break;
    end
    @(posedge clk); #1;
    bus.i_Valid = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      lat++;
      if (bus.o_Valid) break;
      if (!bus.o_Ready) rlow++;
    end
    if (!bus.o_Valid) chk("timeout waiting o_Valid", 32'd0, 32'd1);
    got.alu = bus.o_ALU;
    got.zr = bus.o_ZR;
    got.ng = bus.o_NG;
    got.cy = bus.o_CY;
    got.ov = bus.o_OV;
  endtask

  task automatic expect_res(input string n, input res_t g, input logic [W-1:0] alu,
                            input logic zr, input logic ng, input logic cy, input logic ov);
    chk({n, " alu"}, g.alu, alu);
    chk({n, " zr"}, g.zr, zr);
    chk({n, " ng"}, g.ng, ng);
    chk({n, " cy"}, g.cy, cy);
    chk({n, " ov"}, g.ov, ov);
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    res_t g;
    int lat, rlow, nval;
    bus.i_Valid = 1'b0;
    bus.i_Ready = 1'b1;
    drive('0, '0, 6'b0, 2'd0);
    #1 rst = 1'b1;
    #2;
    chk("reset o_Valid", bus.o_Valid, 0);
    chk("reset o_ALU", bus.o_ALU, 0);
    chk("reset o_ZR", bus.o_ZR, 0);
    chk("reset o_NG", bus.o_NG, 0);
    chk("reset o_CY", bus.o_CY, 0);
    chk("reset o_OV", bus.o_OV, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    chk("post-reset o_Ready", bus.o_Ready, 1);

    run_op(16'd5, 16'd3, 6'b000010, 2'd0, g, lat, rlow);
    expect_res("add 5+3", g, 16'h0008, 0, 0, 0, 0);
    chk("add latency", lat, 1);
    run_op(16'd0, 16'h1234, 6'b001110, 2'd0, g, lat, rlow);
    expect_res("x-1", g, 16'hFFFF, 0, 1, 0, 0);
    run_op(16'hFFFF, 16'd1, 6'b000010, 2'd0, g, lat, rlow);
    expect_res("wrap", g, 16'h0000, 1, 0, 1, 0);
    run_op(16'h7FFF, 16'd1, 6'b000010, 2'd0, g, lat, rlow);
    expect_res("overflow", g, 16'h8000, 0, 1, 0, 1);
    run_op(16'h0001, 16'h0013, 6'b000000, 2'd1, g, lat, rlow);
    expect_res("shl", g, 16'h0008, 0, 0, 0, 0);
    run_op(16'h8000, 16'd4, 6'b000000, 2'd2, g, lat, rlow);
    expect_res("sar", g, 16'hF800, 0, 1, 0, 0);
    run_op(16'd300, 16'd200, 6'b000000, 2'd3, g, lat, rlow);
    expect_res("mul", g, 16'hEA60, 0, 1, 0, 0);
    chk("mul latency", lat, W + 1);
    chk("mul ready-low cycles", rlow, W);
    run_op(16'd300, 16'd200, 6'b000001, 2'd3, g, lat, rlow);
    expect_res("mul no", g, 16'h159F, 0, 0, 0, 0);

    // back-pressure: result and flags must hold while downstream stalls
    @(posedge clk); #1;
    bus.i_Ready = 1'b0;
    run_op(16'h7FFF, 16'd1, 6'b000010, 2'd0, g, lat, rlow);
    repeat (5) begin
      @(negedge clk);
      chk("hold o_Valid", bus.o_Valid, 1);
      chk("hold o_Ready", bus.o_Ready, 0);
      chk("hold o_ALU", bus.o_ALU, 16'h8000);
      chk("hold flags", {bus.o_ZR, bus.o_NG, bus.o_CY, bus.o_OV}, 4'b0101);
    end
    @(posedge clk); #1;
    bus.i_Ready = 1'b1;

    // back-to-back mode-0 ops: one result per cycle
    nval = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      drive(rnd_op(), rnd_op(), 6'($urandom), 2'd0);
      bus.i_Valid = 1'b1;
      @(negedge clk);
      if (bus.o_Valid) nval++;
      chk("b2b o_Ready", bus.o_Ready, 1);
      @(posedge clk); #1;
    end
    bus.i_Valid = 1'b0;
    @(negedge clk);
    if (bus.o_Valid) nval++;
    chk("b2b result count", nval, 8);

    // reset in the middle of a multiply
    run_op(16'h7FFF, 16'd1, 6'b000010, 2'd0, g, lat, rlow);
    @(posedge clk); #1;
    drive(16'd300, 16'd200, 6'b000000, 2'd3);
    bus.i_Valid = 1'b1;
    @(posedge clk); #1;
    bus.i_Valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midreset o_Valid", bus.o_Valid, 0);
    chk("midreset o_ALU", bus.o_ALU, 0);
    chk("midreset flags", {bus.o_ZR, bus.o_NG, bus.o_CY, bus.o_OV}, 4'b0000);
    @(posedge clk);
    #3 rst = 1'b0;
    run_op(16'd300, 16'd200, 6'b000000, 2'd3, g, lat, rlow);
    expect_res("mul after reset", g, 16'hEA60, 0, 1, 0, 0);
    chk("mul after reset latency", lat, W + 1);

    // randomized traffic with random back-pressure
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      bus.i_Valid = ($urandom_range(0, 3) != 0);
      bus.i_Ready = ($urandom_range(0, 4) != 0);
      drive(rnd_op(), rnd_op(), 6'($urandom), 2'($urandom));
    end
    @(posedge clk); #1;
    bus.i_Valid = 1'b0;
    bus.i_Ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
